// File: rtl/conveyor_pkg.sv
// Shared conveyor types and constants, used by the write arbiter and conveyor_control.
package conveyor_pkg;

    localparam int unsigned DEF_WORD_WIDTH          = 32;
    localparam int unsigned DEF_CONVEYOR_ADDR_WIDTH = 4;
    localparam int unsigned DEF_FAULT_ADDR_WIDTH    = 3;
    localparam int unsigned CONVEYOR_WIDTH          = 1;

    localparam logic [DEF_FAULT_ADDR_WIDTH-1:0] F_NONE = '0;

    typedef struct packed {
        logic                            finished;
        logic [DEF_FAULT_ADDR_WIDTH-1:0] fault;
        logic [DEF_WORD_WIDTH-1:0]       value;
    } conveyor_slot_t;

    typedef struct packed {
        logic [CONVEYOR_WIDTH-1:0]          conveyor;
        logic [DEF_CONVEYOR_ADDR_WIDTH-1:0] slot;
        conveyor_slot_t                     data;
    } conveyor_write_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after ptr wins.
module rr_arbiter #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid
);

    always_comb begin
        int unsigned j;
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        j           = 0;
        for (int unsigned k = 0; k < N; k++) begin
            j = (32'(ptr) + k) % N;
            if (!grant_valid && req[j]) begin
                grant_valid = 1'b1;
                grant[j]    = 1'b1;
                grant_idx   = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/conveyor_write_arbiter.sv
// Buffers one result per producer and issues one registered conveyor slot write per cycle,
// round-robin, yielding to hold and discarding work for flushed conveyors.
module conveyor_write_arbiter
    import conveyor_pkg::*;
#(
    parameter int unsigned WORD_WIDTH          = DEF_WORD_WIDTH,
    parameter int unsigned CONVEYOR_ADDR_WIDTH = DEF_CONVEYOR_ADDR_WIDTH,
    parameter int unsigned FAULT_ADDR_WIDTH    = DEF_FAULT_ADDR_WIDTH,
    parameter int unsigned NUM_REQ             = 4
) (
    input  logic                                           clk,
    input  logic                                           reset,
    input  logic [NUM_REQ-1:0]                             req_valid,
    output logic [NUM_REQ-1:0]                             req_ready,
    input  logic [NUM_REQ-1:0]                             req_conveyor,
    input  logic [NUM_REQ-1:0][CONVEYOR_ADDR_WIDTH-1:0]    req_slot,
    input  logic [NUM_REQ-1:0][WORD_WIDTH-1:0]             req_value,
    input  logic [NUM_REQ-1:0][FAULT_ADDR_WIDTH-1:0]       req_fault,
    input  logic                                           hold,
    input  logic [1:0]                                     flush,
    output logic                                           wr_en,
    output logic                                           wr_conveyor,
    output logic [CONVEYOR_ADDR_WIDTH-1:0]                 wr_slot,
    output logic [1+FAULT_ADDR_WIDTH+WORD_WIDTH-1:0]       wr_data,
    output logic [NUM_REQ-1:0]                             pending
);

    localparam int unsigned PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned DATA_W = 1 + FAULT_ADDR_WIDTH + WORD_WIDTH;

    logic [NUM_REQ-1:0]                          pend_q, pend_d;
    logic [NUM_REQ-1:0][CONVEYOR_WIDTH-1:0]      conv_q, conv_d;
    logic [NUM_REQ-1:0][CONVEYOR_ADDR_WIDTH-1:0] slot_q, slot_d;
    logic [NUM_REQ-1:0][WORD_WIDTH-1:0]          value_q, value_d;
    logic [NUM_REQ-1:0][FAULT_ADDR_WIDTH-1:0]    fault_q, fault_d;
    logic [PTR_W-1:0]                            ptr_q, ptr_d;

    logic                                        wr_en_q, wr_en_d;
    logic [CONVEYOR_WIDTH-1:0]                   wr_conv_q, wr_conv_d;
    logic [CONVEYOR_ADDR_WIDTH-1:0]              wr_slot_q, wr_slot_d;
    logic [DATA_W-1:0]                           wr_data_q, wr_data_d;

    logic [NUM_REQ-1:0]                          flushed;
    logic [NUM_REQ-1:0]                          eligible;
    logic [NUM_REQ-1:0]                          grant;
    logic [PTR_W-1:0]                            grant_idx;
    logic                                        grant_valid;

    // Flush and hold only look at state present at the start of the cycle.
    always_comb begin
        flushed = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            flushed[i] = pend_q[i] & flush[conv_q[i]];
        end
        eligible = hold ? '0 : (pend_q & ~flushed);
    end

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (PTR_W)
    ) u_rr_arbiter (
        .req         (eligible),
        .ptr         (ptr_q),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    assign req_ready = ~pend_q | grant;

    // Holding registers: accept wins over the release of the previous occupant.
    always_comb begin
        pend_d  = pend_q;
        conv_d  = conv_q;
        slot_d  = slot_q;
        value_d = value_q;
        fault_d = fault_q;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                pend_d[i]  = 1'b1;
                conv_d[i]  = req_conveyor[i];
                slot_d[i]  = req_slot[i];
                value_d[i] = req_value[i];
                fault_d[i] = req_fault[i];
            end else if (grant[i] || flushed[i]) begin
                pend_d[i] = 1'b0;
            end
        end
    end

    // Output register is fully cleared whenever nothing is granted.
    always_comb begin
        wr_en_d   = 1'b0;
        wr_conv_d = '0;
        wr_slot_d = '0;
        wr_data_d = '0;
        ptr_d     = ptr_q;
        if (grant_valid) begin
            wr_en_d   = 1'b1;
            wr_conv_d = conv_q[grant_idx];
            wr_slot_d = slot_q[grant_idx];
            wr_data_d = {1'b1, fault_q[grant_idx], value_q[grant_idx]};
            ptr_d     = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q    <= '0;
            conv_q    <= '0;
            slot_q    <= '0;
            value_q   <= '0;
            fault_q   <= '0;
            ptr_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_conv_q <= '0;
            wr_slot_q <= '0;
            wr_data_q <= '0;
        end else begin
            pend_q    <= pend_d;
            conv_q    <= conv_d;
            slot_q    <= slot_d;
            value_q   <= value_d;
            fault_q   <= fault_d;
            ptr_q     <= ptr_d;
            wr_en_q   <= wr_en_d;
            wr_conv_q <= wr_conv_d;
            wr_slot_q <= wr_slot_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign wr_en       = wr_en_q;
    assign wr_conveyor = wr_conv_q;
    assign wr_slot     = wr_slot_q;
    assign wr_data     = wr_data_q;
    assign pending     = pend_q;

endmodule

// File: tb/tb_conveyor_write_arbiter.sv
// Scoreboard bench for conveyor_write_arbiter: directed stimulus pushes expected writes, a monitor pops them.
module tb_conveyor_write_arbiter;
    import conveyor_pkg::*;

    localparam int unsigned N  = 4;
    localparam int unsigned AW = 4;
    localparam int unsigned WW = 32;
    localparam int unsigned FW = 3;
    localparam int unsigned DW = 1 + FW + WW;

    typedef struct packed {
        logic          conv;
        logic [AW-1:0] slot;
        logic [DW-1:0] data;
    } exp_t;

    logic                  clk;
    logic                  reset;
    logic [N-1:0]          req_valid;
    logic [N-1:0]          req_ready;
    logic [N-1:0]          req_conveyor;
    logic [N-1:0][AW-1:0]  req_slot;
    logic [N-1:0][WW-1:0]  req_value;
    logic [N-1:0][FW-1:0]  req_fault;
    logic                  hold;
    logic [1:0]            flush;
    logic                  wr_en;
    logic                  wr_conveyor;
    logic [AW-1:0]         wr_slot;
    logic [DW-1:0]         wr_data;
    logic [N-1:0]          pending;

    exp_t exp_q[$];
    int   vectors;
    int   miscompares;

    conveyor_write_arbiter #(
        .WORD_WIDTH          (WW),
        .CONVEYOR_ADDR_WIDTH (AW),
        .FAULT_ADDR_WIDTH    (FW),
        .NUM_REQ             (N)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_conveyor (req_conveyor),
        .req_slot     (req_slot),
        .req_value    (req_value),
        .req_fault    (req_fault),
        .hold         (hold),
        .flush        (flush),
        .wr_en        (wr_en),
        .wr_conveyor  (wr_conveyor),
        .wr_slot      (wr_slot),
        .wr_data      (wr_data),
        .pending      (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic c, input logic [AW-1:0] s, input logic [FW-1:0] f,
                                input logic [WW-1:0] v);
        mk = {c, s, 1'b1, f, v};
    endfunction

    // Monitor: every visible write must match the head of the scoreboard.
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_write: got slot %0d data 0x%0h, expected no write at %0t",
                         wr_slot, wr_data, $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("write", 64'({wr_conveyor, wr_slot, wr_data}), 64'(e));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int p, input logic c, input logic [AW-1:0] s,
                         input logic [FW-1:0] f, input logic [WW-1:0] v);
        req_valid[p]    = 1'b1;
        req_conveyor[p] = c;
        req_slot[p]     = s;
        req_fault[p]    = f;
        req_value[p]    = v;
    endtask

    task automatic idle();
        req_valid = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 60 && (exp_q.size() != 0 || pending != '0); i++) tick();
        tick();
        tick();
        check(name, 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [N-1:0] r;
        int na, nb;
        vectors      = 0;
        miscompares  = 0;
        reset        = 1'b1;
        req_valid    = '0;
        req_conveyor = '0;
        req_slot     = '0;
        req_value    = '0;
        req_fault    = '0;
        hold         = 1'b0;
        flush        = 2'b00;

        // Reset state and single-write latency
        do_reset();
        @(negedge clk);
        check("rst_wr_en", 64'(wr_en), 64'(0));
        check("rst_wr_fields", 64'({wr_conveyor, wr_slot, wr_data}), 64'(0));
        check("rst_pending", 64'(pending), 64'(0));
        check("rst_ready", 64'(req_ready), 64'(4'hF));
        exp_q.push_back(mk(1'b0, 4'd5, F_NONE, 32'hDEADBEEF));
        drive(2, 1'b0, 4'd5, F_NONE, 32'hDEADBEEF);
        tick();
        idle();
        @(negedge clk);
        check("lat_c1_wr_en", 64'(wr_en), 64'(0));
        check("lat_c1_pending", 64'(pending), 64'(4'b0100));
        check("lat_c1_ready2", 64'(req_ready[2]), 64'(1));
        tick();
        @(negedge clk);
        check("lat_c2_wr_en", 64'(wr_en), 64'(1));
        check("lat_c2_ready2", 64'(req_ready[2]), 64'(1));
        tick();
        @(negedge clk);
        check("lat_c3_wr_en", 64'(wr_en), 64'(0));
        wait_drain("drain_single");

        // All four producers at once with pointer at 0
        do_reset();
        exp_q.push_back(mk(1'b0, 4'd0, F_NONE, 32'h0000_1000));
        exp_q.push_back(mk(1'b1, 4'd1, F_NONE, 32'h0000_1001));
        exp_q.push_back(mk(1'b0, 4'd2, F_NONE, 32'h0000_1002));
        exp_q.push_back(mk(1'b0, 4'd3, 3'd5,   32'h0000_1003));
        drive(0, 1'b0, 4'd0, F_NONE, 32'h0000_1000);
        drive(1, 1'b1, 4'd1, F_NONE, 32'h0000_1001);
        drive(2, 1'b0, 4'd2, F_NONE, 32'h0000_1002);
        drive(3, 1'b0, 4'd3, 3'd5,   32'h0000_1003);
        tick();
        idle();
        @(negedge clk);
        check("all4_c1_wr_en", 64'(wr_en), 64'(0));
        for (int k = 2; k <= 5; k++) begin
            tick();
            @(negedge clk);
            check("all4_burst_wr_en", 64'(wr_en), 64'(1));
        end
        tick();
        @(negedge clk);
        check("all4_c6_wr_en", 64'(wr_en), 64'(0));
        wait_drain("drain_all4");

        // Producers 0 and 1 streaming: writes alternate 0,1
        exp_q.push_back(mk(1'b0, 4'd0,  F_NONE, 32'hA000_0000));
        exp_q.push_back(mk(1'b0, 4'd8,  F_NONE, 32'hB000_0000));
        exp_q.push_back(mk(1'b0, 4'd1,  F_NONE, 32'hA000_0001));
        exp_q.push_back(mk(1'b0, 4'd9,  F_NONE, 32'hB000_0001));
        exp_q.push_back(mk(1'b0, 4'd2,  F_NONE, 32'hA000_0002));
        exp_q.push_back(mk(1'b0, 4'd10, F_NONE, 32'hB000_0002));
        exp_q.push_back(mk(1'b0, 4'd3,  F_NONE, 32'hA000_0003));
        na = 0;
        nb = 0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            drive(0, 1'b0, AW'(na),     F_NONE, 32'hA000_0000 + 32'(na));
            drive(1, 1'b0, AW'(8 + nb), F_NONE, 32'hB000_0000 + 32'(nb));
            @(negedge clk);
            r = req_ready;
            tick();
            if (r[0]) na++;
            if (r[1]) nb++;
        end
        idle();
        check("stream_accepts_p0", 64'(na), 64'(4));
        check("stream_accepts_p1", 64'(nb), 64'(3));
        wait_drain("drain_stream");

        // Hold for 3 cycles with two entries loaded; pointer is at 1
        hold = 1'b1;
        exp_q.push_back(mk(1'b0, 4'd9, F_NONE, 32'h3333_0000));
        exp_q.push_back(mk(1'b1, 4'd6, F_NONE, 32'h1111_0000));
        drive(0, 1'b1, 4'd6, F_NONE, 32'h1111_0000);
        drive(3, 1'b0, 4'd9, F_NONE, 32'h3333_0000);
        @(negedge clk);
        check("hold_ready", 64'(req_ready), 64'(4'hF));
        tick();
        idle();
        @(negedge clk);
        check("hold_h1_wr_en", 64'(wr_en), 64'(0));
        check("hold_h1_pending", 64'(pending), 64'(4'b1001));
        tick();
        @(negedge clk);
        check("hold_h2_wr_en", 64'(wr_en), 64'(0));
        tick();
        hold = 1'b0;
        @(negedge clk);
        check("hold_h3_wr_en", 64'(wr_en), 64'(0));
        check("hold_h3_pending", 64'(pending), 64'(4'b1001));
        wait_drain("drain_hold");

        // Flush conveyor 1 with two conveyor-1 entries and one conveyor-0 entry pending
        hold = 1'b1;
        drive(1, 1'b1, 4'd14, F_NONE, 32'h1414_1414);
        drive(2, 1'b1, 4'd15, F_NONE, 32'h1515_1515);
        drive(3, 1'b0, 4'd3,  F_NONE, 32'h0303_0303);
        tick();
        idle();
        hold  = 1'b0;
        flush = 2'b10;
        exp_q.push_back(mk(1'b0, 4'd3, F_NONE, 32'h0303_0303));
        exp_q.push_back(mk(1'b1, 4'd7, F_NONE, 32'h7777_0000));
        drive(0, 1'b1, 4'd7, F_NONE, 32'h7777_0000);
        @(negedge clk);
        check("flush_pending_before", 64'(pending), 64'(4'b1110));
        check("flush_ready", 64'(req_ready), 64'(4'b1001));
        tick();
        flush = 2'b00;
        idle();
        @(negedge clk);
        check("flush_pending_after", 64'(pending), 64'(4'b0001));
        wait_drain("drain_flush");

        // Reset while entries are pending and a write is registered; pointer is at 1
        exp_q.push_back(mk(1'b0, 4'd2, F_NONE, 32'h0000_0002));
        drive(0, 1'b0, 4'd1, F_NONE, 32'h0000_0001);
        drive(1, 1'b0, 4'd2, F_NONE, 32'h0000_0002);
        drive(2, 1'b0, 4'd4, F_NONE, 32'h0000_0004);
        tick();
        idle();
        tick();
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid_pending", 64'(pending), 64'(4'b0101));
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("rst_mid_pending_clr", 64'(pending), 64'(0));
        check("rst_mid_ready", 64'(req_ready), 64'(4'hF));
        for (int k = 0; k < 3; k++) begin
            check("rst_mid_wr_en", 64'(wr_en), 64'(0));
            tick();
            @(negedge clk);
        end
        exp_q.push_back(mk(1'b0, 4'd11, F_NONE, 32'hC0DE_0000));
        exp_q.push_back(mk(1'b0, 4'd12, F_NONE, 32'hC0DE_0001));
        drive(1, 1'b0, 4'd12, F_NONE, 32'hC0DE_0001);
        drive(0, 1'b0, 4'd11, F_NONE, 32'hC0DE_0000);
        tick();
        idle();
        wait_drain("drain_post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
